// File: rtl/div_unit_if.sv
// Execute-to-divider request/response bundle for the multi-cycle DIV/DIVU unit.
// Handshake: master raises start_i with operands and holds it until ready_o is seen;
// it then drops start_i, and result_o stays valid as long as start_i stays high.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic [1:0]            state_dbg;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, state_dbg
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, state_dbg
  );
endinterface

// File: rtl/div_unit.sv
// Restoring 32-bit divider: one quotient bit per cycle, result is {remainder, quotient}.
// state_dbg encodes FREE=0, BYZERO=1, ON=2, END=3.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic         clk,
  input  logic         rst,
  div_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_W-1:0]     dvd_q;
  logic [DATA_W-1:0]     dvs;
  logic [DATA_W-1:0]     rem;
  logic                  sgn_mode;
  logic                  neg1;
  logic                  neg2;
  logic [2*DATA_W-1:0]   result_r;
  logic                  ready_r;

  logic [DATA_W:0]       rem_shift;
  logic [DATA_W:0]       rem_diff;
  logic [DATA_W-1:0]     mag1;
  logic [DATA_W-1:0]     mag2;
  logic [DATA_W-1:0]     quot_fix;
  logic [DATA_W-1:0]     rem_fix;

  // dvd_q starts as the dividend magnitude and fills with quotient bits from the right.
  always_comb begin
    rem_shift = {rem, dvd_q[DATA_W-1]};
    rem_diff  = rem_shift - {1'b0, dvs};
    mag1      = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    mag2      = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;
    quot_fix  = (sgn_mode && (neg1 ^ neg2)) ? -dvd_q : dvd_q;
    rem_fix   = (sgn_mode && neg1) ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= '0;
      dvd_q    <= '0;
      dvs      <= '0;
      rem      <= '0;
      sgn_mode <= 1'b0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      result_r <= '0;
      ready_r  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          result_r <= '0;
          ready_r  <= 1'b0;
          if (bus.start_i && !bus.annul_i) begin
            sgn_mode <= bus.signed_div_i;
            neg1     <= bus.signed_div_i && bus.opdata1_i[DATA_W-1];
            neg2     <= bus.signed_div_i && bus.opdata2_i[DATA_W-1];
            dvd_q    <= mag1;
            dvs      <= mag2;
            rem      <= '0;
            cnt      <= '0;
            state    <= (bus.opdata2_i == '0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          if (bus.annul_i) begin
            state <= FREE;
          end else begin
            result_r <= '0;
            ready_r  <= 1'b1;
            state    <= END;
          end
        end
        ON: begin
          if (bus.annul_i) begin
            cnt   <= '0;
            state <= FREE;
          end else if (cnt != CNT_W'(DATA_W)) begin
            // A clear borrow bit means the shifted remainder covers the divisor.
            if (!rem_diff[DATA_W]) begin
              rem   <= rem_diff[DATA_W-1:0];
              dvd_q <= {dvd_q[DATA_W-2:0], 1'b1};
            end else begin
              rem   <= rem_shift[DATA_W-1:0];
              dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
          end else begin
            result_r <= {rem_fix, quot_fix};
            ready_r  <= 1'b1;
            state    <= END;
          end
        end
        END: begin
          if (!bus.start_i) begin
            result_r <= '0;
            ready_r  <= 1'b0;
            cnt      <= '0;
            state    <= FREE;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

  assign bus.result_o  = result_r;
  assign bus.ready_o   = ready_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases from the test plan plus randomized
// divisions against a 64-bit arithmetic reference model.
module tb_div_unit;

  localparam int DATA_W = 32;
  localparam logic [1:0] ST_FREE = 2'd0;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  div_unit_if #(.DATA_W(DATA_W)) bus ();

  div_unit #(.DATA_W(DATA_W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: widen to 64 bits so that INT_MIN / -1 wraps naturally on truncation.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
  endtask

  // Driver: issue one division, count edges until ready_o, then drop start_i and
  // check the release. scramble>0 randomizes operand inputs after that many edges.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int scramble, output logic [63:0] res, output int edges);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = s;
    bus.start_i      = 1'b1;
    edges = 0;
    res   = '0;
    while (1) begin
      tick();
      edges++;
      if (scramble > 0 && edges == scramble) begin
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
      end
      if (bus.ready_o === 1'b1) break;
      if (edges >= 80) begin
        n_checks++;
        n_fail++;
        $display("FAIL ready_timeout: ready_o not seen after %0d edges, required within 34", edges);
        break;
      end
    end
    res = bus.result_o;
    bus.start_i = 1'b0;
    tick();
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL release: ready_o=%b result_o=%h, required 0 and 0", bus.ready_o, bus.result_o);
    end
  endtask

  task automatic check_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input int scramble);
    logic [63:0] res;
    logic [63:0] exp_res;
    int edges;
    int exp_edges;
    exp_res   = ref_div(a, b, s);
    exp_edges = (b == 32'd0) ? 2 : 34;
    run_div(a, b, s, scramble, res, edges);
    n_checks++;
    if (res !== exp_res) begin
      n_fail++;
      $display("FAIL %s result: a=%h b=%h s=%b got %h, required %h", name, a, b, s, res, exp_res);
    end
    n_checks++;
    if (edges !== exp_edges) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, required %0d", name, edges, exp_edges);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0 || bus.state_dbg !== ST_FREE) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b result=%h state=%0d, required 0/0/FREE",
               bus.ready_o, bus.result_o, bus.state_dbg);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_unsigned();
    check_div("udiv_100_7", 32'd100, 32'd7, 1'b0, 0);
    check_div("udiv_ffff_10", 32'hFFFFFFFF, 32'h10, 1'b0, 0);
  endtask

  task automatic test_signed();
    check_div("sdiv_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 0);
    check_div("sdiv_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 0);
    check_div("sdiv_m7_m2", 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 0);
  endtask

  task automatic test_div_zero();
    check_div("div_zero", 32'd5, 32'd0, 1'b0, 0);
    check_div("sdiv_zero", 32'h80000000, 32'd0, 1'b1, 0);
  endtask

  task automatic test_annul();
    bit saw_ready;
    saw_ready = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    tick();
    repeat (9) begin
      tick();
      if (bus.ready_o === 1'b1) saw_ready = 1'b1;
    end
    bus.annul_i = 1'b1;
    tick();
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    n_checks++;
    if (bus.state_dbg !== ST_FREE) begin
      n_fail++;
      $display("FAIL annul_state: state=%0d, required FREE(0)", bus.state_dbg);
    end
    repeat (40) begin
      tick();
      if (bus.ready_o === 1'b1) saw_ready = 1'b1;
    end
    n_checks++;
    if (saw_ready) begin
      n_fail++;
      $display("FAIL annul_ready: ready_o asserted=1, required never");
    end
    check_div("after_annul", 32'hFFFFFFFF, 32'h10, 1'b0, 0);
  endtask

  task automatic test_overflow();
    check_div("sdiv_overflow", 32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
    check_div("mid_on_change", 32'd123456789, 32'd1000, 1'b0, 5);
    check_div("mid_on_change_s", 32'hF0000001, 32'd77, 1'b1, 17);
  endtask

  task automatic test_reset_mid();
    logic [31:0] a2;
    logic [31:0] b2;
    logic [63:0] exp_res;
    int edges;
    a2 = $urandom;
    b2 = $urandom_range(1, 5000);
    exp_res = ref_div(a2, b2, 1'b0);
    bus.opdata1_i    = 32'd999999;
    bus.opdata2_i    = 32'd13;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    repeat (21) tick();
    rst = 1'b0;
    bus.opdata1_i = a2;
    bus.opdata2_i = b2;
    tick();
    n_checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0 || bus.state_dbg !== ST_FREE) begin
      n_fail++;
      $display("FAIL reset_mid_state: ready=%b result=%h state=%0d, required 0/0/FREE",
               bus.ready_o, bus.result_o, bus.state_dbg);
    end
    rst = 1'b1;
    edges = 0;
    while (bus.ready_o !== 1'b1 && edges < 80) begin
      tick();
      edges++;
    end
    n_checks++;
    if (edges !== 34) begin
      n_fail++;
      $display("FAIL reset_mid_latency: got %0d edges, required 34", edges);
    end
    n_checks++;
    if (bus.result_o !== exp_res) begin
      n_fail++;
      $display("FAIL reset_mid_result: got %h, required %h", bus.result_o, exp_res);
    end
    bus.start_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic s;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'hFFFFFFFF - $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      check_div("random", a, b, s, 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
